// File: rtl/pf_iod_tx_pkg.sv
// Shared types and default lane words for the PolarFire IOD generic TX framer.
package pf_iod_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    DATA  = 2'd2
  } state_e;

  localparam logic [7:0] DEF_TRAIN_WORD = 8'hE4;
  localparam logic [7:0] DEF_IDLE_WORD  = 8'h00;

endpackage

// File: rtl/pf_iod_tx_fifo.sv
// Synchronous show-ahead FIFO buffering parallel lane words ahead of the framer.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module pf_iod_tx_fifo
  import pf_iod_tx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the counter alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pf_iod_generic_tx_framer.sv
// Word framer for the IOD TX serializers: emits training for RX bit-slip
// alignment, then streams buffered payload and fills gaps with idle words.
module pf_iod_generic_tx_framer
  import pf_iod_tx_pkg::*;
#(
  parameter int         LANES      = 4,
  parameter logic [7:0] TRAIN_WORD = DEF_TRAIN_WORD,
  parameter logic [7:0] IDLE_WORD  = DEF_IDLE_WORD,
  parameter int         TRAIN_LEN  = 128,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               TX_EN,
  input  logic               TRAIN_REQ,
  input  logic [LANES*8-1:0] DATA_IN,
  input  logic               DATA_VALID,
  output logic               DATA_READY,
  output logic [LANES*8-1:0] TXD,
  output logic               TRAINING,
  output logic               TRAIN_DONE,
  output logic               UNDERRUN
);

  localparam int                W        = LANES * 8;
  localparam int                CNT_W    = $clog2(TRAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     txd_q, txd_d;
  logic             training_q, training_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;

  logic [W-1:0]     fifo_head;
  logic             fifo_full, fifo_empty;
  logic             push, pop;

  assign DATA_READY = RST_N && !fifo_full;
  assign push       = DATA_VALID && DATA_READY;

  pf_iod_tx_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (DATA_IN),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs are decoded from the next state so the first training cycle
  // lands directly after TRAIN_REQ is sampled.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == TRAIN) ? cnt_q + 1'b1 : '0;
    txd_d      = {LANES{IDLE_WORD}};
    training_d = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE:    if (TRAIN_REQ) state_d = TRAIN;
      TRAIN:   if (cnt_q == CNT_LAST) state_d = TX_EN ? DATA : IDLE;
      DATA: begin
        if (TRAIN_REQ)   state_d = TRAIN;
        else if (!TX_EN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      TRAIN: begin
        txd_d      = {LANES{TRAIN_WORD}};
        training_d = 1'b1;
        done_d     = (cnt_d == CNT_LAST);
      end
      DATA: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          txd_d = fifo_head;
        end else begin
          underrun_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      txd_q      <= {LANES{IDLE_WORD}};
      training_q <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txd_q      <= txd_d;
      training_q <= training_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign TXD        = txd_q;
  assign TRAINING   = training_q;
  assign TRAIN_DONE = done_q;
  assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_pf_iod_generic_tx_framer.sv
// Directed self-checking bench for pf_iod_generic_tx_framer with TRAIN_LEN=4
// and FIFO_DEPTH=4; outputs are sampled 1 time unit after each rising edge.
module tb_pf_iod_generic_tx_framer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        TX_EN = 1'b0;
  logic        TRAIN_REQ = 1'b0;
  logic        DATA_VALID = 1'b0;
  logic [31:0] DATA_IN = '0;
  logic        DATA_READY;
  logic [31:0] TXD;
  logic        TRAINING;
  logic        TRAIN_DONE;
  logic        UNDERRUN;

  int compared = 0;
  int mismatched = 0;

  localparam logic [31:0] TRAIN_ALL = 32'hE4E4E4E4;
  localparam logic [31:0] IDLE_ALL  = 32'h00000000;

  logic [31:0] fillWords [5] = '{32'h40414243, 32'h44454647, 32'h48494A4B,
                                 32'h4C4D4E4F, 32'h50515253};

  pf_iod_generic_tx_framer #(
    .LANES      (4),
    .TRAIN_WORD (8'hE4),
    .IDLE_WORD  (8'h00),
    .TRAIN_LEN  (4),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .TX_EN      (TX_EN),
    .TRAIN_REQ  (TRAIN_REQ),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .TXD        (TXD),
    .TRAINING   (TRAINING),
    .TRAIN_DONE (TRAIN_DONE),
    .UNDERRUN   (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic txEn, input logic trainReq,
                               input logic valid, input logic [31:0] data);
    TX_EN      = txEn;
    TRAIN_REQ  = trainReq;
    DATA_VALID = valid;
    DATA_IN    = data;
  endtask

  // Expects TRAIN_REQ already high; clocks through the 4 training cycles.
  task automatic checkTraining(input string tag, input logic expReady);
    for (int i = 0; i < 4; i++) begin
      tick();
      TRAIN_REQ = 1'b0;
      checkOutput({tag, "_txd"},      TXD, TRAIN_ALL);
      checkOutput({tag, "_training"}, {31'b0, TRAINING}, 32'd1);
      checkOutput({tag, "_done"},     {31'b0, TRAIN_DONE}, (i == 3) ? 32'd1 : 32'd0);
      checkOutput({tag, "_underrun"}, {31'b0, UNDERRUN}, 32'd0);
      checkOutput({tag, "_ready"},    {31'b0, DATA_READY}, {31'b0, expReady});
    end
  endtask

  task automatic checkData(input string tag, input logic [31:0] expTxd, input logic expUnder);
    checkOutput({tag, "_txd"},      TXD, expTxd);
    checkOutput({tag, "_underrun"}, {31'b0, UNDERRUN}, {31'b0, expUnder});
    checkOutput({tag, "_training"}, {31'b0, TRAINING}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    checkData("rst", IDLE_ALL, 1'b0);
    checkOutput("rst_done",  {31'b0, TRAIN_DONE}, 32'd0);
    checkOutput("rst_ready", {31'b0, DATA_READY}, 32'd0);

    // Training after reset, then DATA with empty FIFO
    RST_N = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkTraining("train1", 1'b1);
    tick();
    checkData("train1_exit", IDLE_ALL, 1'b1);

    // Back-to-back payload into an empty FIFO
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h03020100);
    tick();
    checkData("pay_a", IDLE_ALL, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h07060504);
    tick();
    checkData("pay_b", 32'h03020100, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkData("pay_c", 32'h07060504, 1'b0);
    tick();
    checkData("pay_d", IDLE_ALL, 1'b1);

    // Fill FIFO in IDLE; fifth word must be refused
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkData("to_idle", IDLE_ALL, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("fill_ready%0d", i), {31'b0, DATA_READY}, (i < 4) ? 32'd1 : 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, fillWords[i]);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkData("txen_only", IDLE_ALL, 1'b0);
    checkOutput("txen_only_ready", {31'b0, DATA_READY}, 32'd0);

    // Training with full FIFO; then a pop while DATA_VALID is held must not push
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    checkTraining("train_full", 1'b0);
    tick();
    checkData("drain0", fillWords[0], 1'b0);
    checkOutput("ready_rise", {31'b0, DATA_READY}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      checkData($sformatf("drain%0d", i), fillWords[i], 1'b0);
    end
    tick();
    checkData("drain_end", IDLE_ALL, 1'b1);

    // TRAIN_REQ beats TX_EN low in DATA; buffered words survive
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hA0A1A2A3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hB0B1B2B3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC0C1C2C3);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkTraining("train_x", 1'b1);
    tick();
    checkData("x0", 32'hA0A1A2A3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkTraining("prio", 1'b1);
    tick();
    checkData("prio_idle", IDLE_ALL, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkTraining("resume", 1'b1);
    tick();
    checkData("x1", 32'hB0B1B2B3, 1'b0);
    tick();
    checkData("x2", 32'hC0C1C2C3, 1'b0);
    tick();
    checkData("x_end", IDLE_ALL, 1'b1);

    // Reset mid-training at counter=2 aborts and empties FIFO
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h99887766);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    TRAIN_REQ = 1'b0;
    tick();
    tick();
    checkOutput("mid_training", {31'b0, TRAINING}, 32'd1);
    checkOutput("mid_done", {31'b0, TRAIN_DONE}, 32'd0);
    RST_N = 1'b0;
    tick();
    checkData("abort", IDLE_ALL, 1'b0);
    checkOutput("abort_done",  {31'b0, TRAIN_DONE}, 32'd0);
    checkOutput("abort_ready", {31'b0, DATA_READY}, 32'd0);
    RST_N = 1'b1;
    tick();
    checkData("post_rst", IDLE_ALL, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkTraining("post_rst_train", 1'b1);
    tick();
    checkData("post_rst_empty", IDLE_ALL, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
